// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner: synchronise, debounce, press/release
// edge pulses and optional auto-repeat while a button stays held.
module btn_conditioner #(
  parameter int              N_CH          = 3,
  parameter int              STABLE_CYCLES = 1000000,
  parameter int              REPEAT_DELAY  = 50000000,
  parameter int              REPEAT_RATE   = 10000000,
  parameter logic [N_CH-1:0] REPEAT_EN     = '1,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = '0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  // state    | meaning
  // RELEASED | debounced level is 0, repeat counter idle at 0
  // HELD     | debounced level is 1, repeat counter running
  typedef enum logic {RELEASED = 1'b0, HELD = 1'b1} state_t;

  localparam int SW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [SW-1:0] STABLE_TC = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_TC  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_TC   = RW'(REPEAT_RATE - 1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;

  // Polarity-normalise raw inputs, then two-flop synchronise them.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in ^ ACTIVE_LOW;
      s2 <= s1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SW-1:0] stab_cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          toggle;
    logic          level_d;
    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] rep_cnt;
    logic          rep_done;
    logic          rep_hit;
    logic          repeat_q;

    // A level change is accepted on the edge where the counter sits at terminal count.
    always_comb begin
      toggle  = (s2[ch] != level_q) && (stab_cnt == STABLE_TC);
      level_d = level_q ^ toggle;
    end

    // Stability counter, debounced level and registered edge pulses.
    always_ff @(posedge clk) begin
      if (clr) begin
        stab_cnt  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if ((s2[ch] == level_q) || toggle) begin
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
        level_q   <= level_d;
        press_q   <= toggle & ~level_q;
        release_q <= toggle & level_q;
      end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
      if (clr) begin
        state_q <= RELEASED;
      end else begin
        state_q <= state_d;
      end
    end

    // FSM next state follows the debounced level as it is being written.
    always_comb begin
      state_d = state_q;
      case (state_q)
        RELEASED: if (level_d)  state_d = HELD;
        HELD:     if (!level_d) state_d = RELEASED;
        default:  state_d = RELEASED;
      endcase
    end

    // FSM output: repeat hit only while staying HELD, so never on press or release edges.
    always_comb begin
      rep_hit = 1'b0;
      if (REPEAT_EN[ch] && (state_q == HELD) && (state_d == HELD)) begin
        rep_hit = rep_done ? (rep_cnt == RATE_TC) : (rep_cnt == DELAY_TC);
      end
    end

    // Repeat counter: restarts on entry to HELD and after every repeat pulse.
    always_ff @(posedge clk) begin
      if (clr) begin
        rep_cnt  <= '0;
        rep_done <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        if ((state_q != HELD) || (state_d != HELD)) begin
          rep_cnt  <= '0;
          rep_done <= 1'b0;
        end else if (rep_hit) begin
          rep_cnt  <= '0;
          rep_done <= 1'b1;
        end else if (REPEAT_EN[ch]) begin
          rep_cnt  <= rep_cnt + 1'b1;
        end
        repeat_q <= rep_hit;
      end
    end

    assign btn_level[ch]   = level_q;
    assign btn_press[ch]   = press_q;
    assign btn_release[ch] = release_q;
    assign btn_repeat[ch]  = repeat_q;
  end

endmodule
